// File: rtl/fb_pkg.sv
// Frame-buffer constants and types shared by the arbiter and the pixel generator.
package fb_pkg;

    localparam int FB_WIDTH   = 320;
    localparam int FB_HEIGHT  = 240;
    localparam int FB_DEPTH   = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W     = 17;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              data;
    } fb_wr_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Video, drawing-write, clear-control and RAM signals of the frame-buffer arbiter.
interface fb_port_arbiter_if;
    import fb_pkg::*;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              clear_req;
    logic              clear_value;
    logic              clear_busy;
    logic              clear_done;
    logic              addr_err;
    logic              err_clr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_wdata;
    logic              mem_rdata;

    // The arbiter is the slave of its clients; the client side also models the RAM.
    modport slave (
        input  vid_req, vid_addr, wr_valid, wr_addr, wr_data,
               clear_req, clear_value, err_clr, mem_rdata,
        output vid_data, wr_ready, clear_busy, clear_done, addr_err,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vid_req, vid_addr, wr_valid, wr_addr, wr_data,
               clear_req, clear_value, err_clr, mem_rdata,
        input  vid_data, wr_ready, clear_busy, clear_done, addr_err,
               mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/fb_write_fifo.sv
// Small synchronous FIFO holding pending drawing writes {addr,data}.
module fb_write_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr];

    // Storage carries no reset; only pointers and count are control state.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame RAM arbiter: video reads first, then the clear engine, then queued drawing writes.
module fb_port_arbiter #(
    parameter int ADDR_W     = fb_pkg::ADDR_W,
    parameter int FB_DEPTH   = fb_pkg::FB_DEPTH,
    parameter int FIFO_DEPTH = fb_pkg::FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset_n,
    fb_port_arbiter_if.slave bus
);
    import fb_pkg::*;

    localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(FB_DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(FB_DEPTH - 1);

    fb_state_t         r_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_clr_value;
    logic              r_clear_busy;
    logic              r_clear_done;
    logic              r_addr_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic              r_mem_wdata;
    logic              r_vtag_p0;
    logic              r_vtag_p1;
    logic              r_vid_data;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    fb_wr_t            w_head;
    fb_wr_t            w_din;
    logic              w_wr_ready;
    logic              w_push_hs;
    logic              w_bad_addr;
    logic              w_push;
    logic              w_clr_slot;
    logic              w_pop;

    assign w_wr_ready = !w_fifo_full && (r_state == IDLE);
    assign w_push_hs  = bus.wr_valid && w_wr_ready;
    assign w_bad_addr = (bus.wr_addr >= LP_DEPTH);
    assign w_push     = w_push_hs && !w_bad_addr;
    assign w_clr_slot = !bus.vid_req && (r_state == CLEAR);
    assign w_pop      = !bus.vid_req && (r_state != CLEAR) && !w_fifo_empty;
    assign w_din      = '{addr: bus.wr_addr, data: bus.wr_data};

    fb_write_fifo #(
        .WIDTH ($bits(fb_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_clr_addr   <= '0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
            r_addr_err   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 1'b0;
            r_vtag_p0    <= 1'b0;
            r_vtag_p1    <= 1'b0;
            r_vid_data   <= 1'b0;
        end else begin
            // Read-tag pipeline: p0 = address on the RAM, p1 = data on mem_rdata.
            r_vtag_p0 <= bus.vid_req;
            r_vtag_p1 <= r_vtag_p0;
            if (r_vtag_p1) r_vid_data <= bus.mem_rdata;

            if (bus.vid_req) begin
                r_mem_addr <= bus.vid_addr;
                r_mem_we   <= 1'b0;
            end else if (w_clr_slot) begin
                r_mem_addr  <= r_clr_addr;
                r_mem_we    <= 1'b1;
                r_mem_wdata <= r_clr_value;
            end else if (w_pop) begin
                r_mem_addr  <= w_head.addr;
                r_mem_we    <= 1'b1;
                r_mem_wdata <= w_head.data;
            end else begin
                r_mem_we <= 1'b0;
            end

            // A new bad write outranks a simultaneous clear request.
            if (w_push_hs && w_bad_addr) r_addr_err <= 1'b1;
            else if (bus.err_clr)        r_addr_err <= 1'b0;

            r_clear_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.clear_req) begin
                        r_clr_value  <= bus.clear_value;
                        r_clear_busy <= 1'b1;
                        // A write pushed in this same cycle must still drain first.
                        if (w_fifo_empty && !w_push) begin
                            r_state    <= CLEAR;
                            r_clr_addr <= '0;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_fifo_empty) begin
                        r_state    <= CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    if (w_clr_slot) begin
                        if (r_clr_addr == LP_LAST) begin
                            r_state      <= IDLE;
                            r_clear_busy <= 1'b0;
                            r_clear_done <= 1'b1;
                        end else begin
                            r_clr_addr <= r_clr_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_clear_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vid_data   = r_vid_data;
    assign bus.wr_ready   = w_wr_ready;
    assign bus.clear_busy = r_clear_busy;
    assign bus.clear_done = r_clear_done;
    assign bus.addr_err   = r_addr_err;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule
